core_mem_host: RTL

CORE_MEM_HOST -- requirements
Module: core_mem_host

---
 rtl/core_mem_pkg.sv | 15 +
 rtl/dmem_ram.sv | 22 ++
 rtl/core_mem_host.sv | 101 ++++++++++
 3 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and address-map constants for the core memory host.
package core_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] DMEM_BASE = 32'h0000_1000;
  localparam logic [31:0] HALT_ADDR = 32'h0000_2000;

endpackage

// File: rtl/dmem_ram.sv
// Data memory: synchronous write, asynchronous read (old data on same-word RAW).
module dmem_ram #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/core_mem_host.sv
// Hosts a core's instruction/data memories: program load, run, halt on a
// store to HALT_ADDR, and fault on illegal fetches or stores.
module core_mem_host
  import core_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   PC,
  input  logic [31:0]                   ALURes,
  input  logic                          MemWrite,
  input  logic [31:0]                   WriteData,
  output logic [31:0]                   Instruction,
  output logic [31:0]                   ReadData,
  output logic                          core_reset,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [$clog2(IMEM_WORDS)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  input  logic                          load_last,
  output logic                          running,
  output logic                          halted,
  output logic                          fault,
  output logic [31:0]                   halt_value,
  output logic [31:0]                   cycle_count
);

  localparam int          IAW        = $clog2(IMEM_WORDS);
  localparam int          DAW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

  state_e      state, state_nxt;
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dofs, dmem_rd;
  logic        pc_ok, dmem_hit, st_dmem, st_halt, st_bad;
  logic        load_fire, dmem_we;

  // Offset below DMEM_BASE wraps to a huge value, so one compare covers both bounds.
  assign dofs     = ALURes - DMEM_BASE;
  assign dmem_hit = dofs < DMEM_BYTES;
  assign pc_ok    = (PC < IMEM_BYTES) && (PC[1:0] == 2'b00);

  assign st_dmem  = MemWrite && dmem_hit && (ALURes[1:0] == 2'b00);
  assign st_halt  = MemWrite && (ALURes == HALT_ADDR);
  assign st_bad   = MemWrite && !st_dmem && !st_halt;

  assign load_ready = (state == ST_LOAD);
  assign load_fire  = load_ready && load_valid;
  assign running    = (state == ST_RUN);
  assign halted     = (state == ST_HALT);
  assign fault      = (state == ST_FAULT);

  assign Instruction = (running && pc_ok) ? imem[PC[IAW+1:2]] : NOP;
  assign ReadData    = dmem_hit ? dmem_rd : 32'h0;

  always_ff @(posedge clk) begin
    if (load_fire) imem[load_addr] <= load_data;
  end

  dmem_ram #(.WORDS(DMEM_WORDS)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (dofs[DAW+1:2]),
    .wdata (WriteData),
    .raddr (dofs[DAW+1:2]),
    .rdata (dmem_rd)
  );

  // A fetch fault wins over any store; stores only commit on clean cycles.
  always_comb begin
    state_nxt = state;
    dmem_we   = 1'b0;
    case (state)
      ST_LOAD: if (load_fire && load_last) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!pc_ok || st_bad) state_nxt = ST_FAULT;
        else if (st_halt)     state_nxt = ST_HALT;
        else                  dmem_we   = st_dmem;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD;
      core_reset  <= 1'b1;
      halt_value  <= 32'h0;
      cycle_count <= 32'h0;
    end else begin
      state      <= state_nxt;
      core_reset <= (state_nxt != ST_RUN);
      if (running && state_nxt == ST_HALT) halt_value <= WriteData;
      if (running && cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule
